// File: rtl/buffer_ctrl_if.sv
`default_nettype none
// ============================================================================
// buffer_ctrl_if : producer/consumer handshake and buffer-control bundle
// Revision: 1.0
// ============================================================================
interface buffer_ctrl_if #(
  parameter int BUFFER_ADDR = 3
);
  logic                   wr_valid;
  logic                   wr_last;
  logic                   wr_ready;
  logic                   rd_valid;
  logic                   rd_ready;
  logic                   buf_write_en;
  logic [BUFFER_ADDR-1:0] buf_write_addr;
  logic                   buf_read_en;
  logic [BUFFER_ADDR-1:0] buf_read_addr;
  logic [BUFFER_ADDR:0]   count;
  logic                   frame_done;

  modport master (
    output wr_valid, wr_last, rd_ready,
    input  wr_ready, rd_valid, buf_write_en, buf_write_addr,
           buf_read_en, buf_read_addr, count, frame_done
  );

  modport slave (
    input  wr_valid, wr_last, rd_ready,
    output wr_ready, rd_valid, buf_write_en, buf_write_addr,
           buf_read_en, buf_read_addr, count, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/buffer_ctrl.sv
`default_nettype none
// ============================================================================
// buffer_ctrl : pointer/occupancy/frame controller for a parallel-write,
//               sliding-window-read circular buffer
// Revision: 1.0
// ============================================================================
module buffer_ctrl #(
  parameter int PAR_WRITE   = 2,
  parameter int PAR_READ    = 4,
  parameter int POP_STRIDE  = 1,
  parameter int BUFFER_ADDR = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  buffer_ctrl_if.slave bus
);
  localparam int DEPTH = 1 << BUFFER_ADDR;
  localparam int CW    = BUFFER_ADDR + 2;

  localparam logic [CW-1:0] c_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] c_PW    = CW'(PAR_WRITE);
  localparam logic [CW-1:0] c_PR    = CW'(PAR_READ);
  localparam logic [CW-1:0] c_PS    = CW'(POP_STRIDE);
  localparam logic [BUFFER_ADDR-1:0] c_PW_A = BUFFER_ADDR'(PAR_WRITE);
  localparam logic [BUFFER_ADDR-1:0] c_PS_A = BUFFER_ADDR'(POP_STRIDE);

  localparam logic [1:0] S_FILL  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]             r_state;
  logic [1:0]             w_next_state;
  logic [BUFFER_ADDR-1:0] r_wr_ptr;
  logic [BUFFER_ADDR-1:0] r_rd_ptr;
  logic [BUFFER_ADDR:0]   r_count;
  logic [CW-1:0]          w_count_ext;
  logic [CW-1:0]          w_space;
  logic [CW-1:0]          w_count_nxt;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_wr_ready;
  logic                   w_rd_valid;
  logic                   w_frame_done;

  assign w_count_ext = {1'b0, r_count};
  assign w_space     = c_DEPTH - w_count_ext;
  assign w_push      = w_wr_ready & bus.wr_valid;
  assign w_pop       = w_rd_valid & bus.rd_ready;
  assign w_count_nxt = w_count_ext + (w_push ? c_PW : '0) - (w_pop ? c_PS : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FILL:  if (w_push && bus.wr_last) w_next_state = S_DRAIN;
      // Exit decision uses the registered count; a pop that drops below the
      // window size is seen on the following cycle.
      S_DRAIN: if (w_count_ext < c_PR) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_FILL;
      default: w_next_state = S_FILL;
    endcase
  end

  // Gated by rst_n so every handshake output is low while reset is held.
  always_comb begin
    w_wr_ready   = rst_n && (r_state == S_FILL) && (w_space >= c_PW);
    w_rd_valid   = rst_n && (r_state != S_DONE) && (w_count_ext >= c_PR);
    w_frame_done = rst_n && (r_state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (r_state == S_DONE) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PW_A;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PS_A;
      r_count <= w_count_nxt[BUFFER_ADDR:0];
    end
  end

  assign bus.wr_ready       = w_wr_ready;
  assign bus.rd_valid       = w_rd_valid;
  assign bus.buf_write_en   = w_push;
  assign bus.buf_write_addr = r_wr_ptr;
  assign bus.buf_read_en    = w_rd_valid;
  assign bus.buf_read_addr  = r_rd_ptr;
  assign bus.count          = r_count;
  assign bus.frame_done     = w_frame_done;
endmodule
`default_nettype wire

// File: tb/tb_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// tb_buffer_ctrl : directed plus randomized bench for buffer_ctrl, checked
//                  against a word-queue model of buffer occupancy
// Revision: 1.0
// ============================================================================
module tb_buffer_ctrl;
  localparam int PW    = 2;
  localparam int PR    = 4;
  localparam int PS    = 1;
  localparam int BA    = 3;
  localparam int DEPTH = 1 << BA;

  localparam int PH_FILL  = 0;
  localparam int PH_DRAIN = 1;
  localparam int PH_DONE  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  buffer_ctrl_if #(.BUFFER_ADDR(BA)) bus ();

  buffer_ctrl #(
    .PAR_WRITE  (PW),
    .PAR_READ   (PR),
    .POP_STRIDE (PS),
    .BUFFER_ADDR(BA)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the buffer holds a queue of word addresses, oldest first.
  int q[$];
  int m_pushes = 0;
  int m_phase  = PH_FILL;

  always @(negedge clk) begin : b_check
    int  size;
    int  e_waddr;
    int  e_raddr;
    bit  e_wr_ready;
    bit  e_rd_valid;
    bit  push;
    bit  pop;
    if (!rst_n) begin
      q.delete();
      m_pushes = 0;
      m_phase  = PH_FILL;
      chk("rst_wr_ready", 32'(bus.wr_ready), 0);
      chk("rst_rd_valid", 32'(bus.rd_valid), 0);
      chk("rst_count",    32'(bus.count), 0);
      chk("rst_wen",      32'(bus.buf_write_en), 0);
      chk("rst_ren",      32'(bus.buf_read_en), 0);
      chk("rst_done",     32'(bus.frame_done), 0);
    end else begin
      size       = q.size();
      e_waddr    = (m_pushes * PW) % DEPTH;
      e_raddr    = (size > 0) ? q[0] : e_waddr;
      e_wr_ready = (m_phase == PH_FILL) && (DEPTH - size >= PW);
      e_rd_valid = (m_phase != PH_DONE) && (size >= PR);
      push       = bus.wr_valid && e_wr_ready;
      pop        = e_rd_valid && bus.rd_ready;
      chk("wr_ready",   32'(bus.wr_ready), 32'(e_wr_ready));
      chk("rd_valid",   32'(bus.rd_valid), 32'(e_rd_valid));
      chk("count",      32'(bus.count), size);
      chk("wen",        32'(bus.buf_write_en), 32'(push));
      chk("waddr",      32'(bus.buf_write_addr), e_waddr);
      chk("ren",        32'(bus.buf_read_en), 32'(e_rd_valid));
      chk("raddr",      32'(bus.buf_read_addr), e_raddr);
      chk("frame_done", 32'(bus.frame_done), 32'(m_phase == PH_DONE));
      if (m_phase == PH_DONE) begin
        q.delete();
        m_pushes = 0;
        m_phase  = PH_FILL;
      end else begin
        if (push) begin
          for (int k = 0; k < PW; k++) q.push_back((e_waddr + k) % DEPTH);
          m_pushes++;
        end
        if (pop) begin
          for (int k = 0; k < PS; k++) void'(q.pop_front());
        end
        if (m_phase == PH_FILL && push && bus.wr_last) m_phase = PH_DRAIN;
        else if (m_phase == PH_DRAIN && size < PR)      m_phase = PH_DONE;
      end
    end
  end

  task automatic step(input logic wv, input logic wl, input logic rr);
    bus.wr_valid = wv;
    bus.wr_last  = wl;
    bus.rd_ready = rr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_last  = 1'b0;
    bus.rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("t0_count",    32'(bus.count), 0);
    chk("t0_wr_ready", 32'(bus.wr_ready), 0);
    rst_n = 1'b1;
    #1;
    chk("t0_ready_after_rel", 32'(bus.wr_ready), 1);

    step(1, 0, 0);
    step(1, 0, 0);
    chk("t1_count",    32'(bus.count), 4);
    chk("t1_rd_valid", 32'(bus.rd_valid), 1);
    chk("t1_raddr",    32'(bus.buf_read_addr), 0);
    step(1, 0, 0);
    chk("t1_count3",   32'(bus.count), 6);
    step(1, 0, 0);
    chk("t2_full",     32'(bus.count), 8);
    chk("t2_blocked",  32'(bus.wr_ready), 0);
    step(0, 0, 1);
    chk("t2_count7",   32'(bus.count), 7);
    chk("t2_block7",   32'(bus.wr_ready), 0);
    step(0, 0, 1);
    chk("t2_count6",   32'(bus.count), 6);
    chk("t2_ready6",   32'(bus.wr_ready), 1);
    step(1, 0, 1);
    chk("t4_pushpop",  32'(bus.count), 7);
    repeat (3) step(0, 0, 1);
    chk("t5_count4",   32'(bus.count), 4);
    step(1, 1, 0);
    chk("t5_drain_cnt",   32'(bus.count), 6);
    chk("t5_drain_ready", 32'(bus.wr_ready), 0);
    repeat (3) step(0, 0, 1);
    chk("t5_tail_cnt",    32'(bus.count), 3);
    chk("t5_tail_valid",  32'(bus.rd_valid), 0);
    chk("t5_tail_done",   32'(bus.frame_done), 0);
    step(0, 0, 0);
    chk("t5_done_pulse",  32'(bus.frame_done), 1);
    step(0, 0, 0);
    chk("t5_done_clear",  32'(bus.frame_done), 0);
    chk("t5_count0",      32'(bus.count), 0);
    chk("t5_fill_ready",  32'(bus.wr_ready), 1);

    step(1, 0, 0);
    step(1, 1, 0);
    chk("t6_pre_valid",   32'(bus.rd_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rd_valid",    32'(bus.rd_valid), 0);
    chk("t6_wr_ready",    32'(bus.wr_ready), 0);
    chk("t6_count",       32'(bus.count), 0);
    chk("t6_ren",         32'(bus.buf_read_en), 0);
    step(0, 0, 0);
    rst_n = 1'b1;
    #1;
    chk("t6_rel_count",   32'(bus.count), 0);
    chk("t6_rel_ready",   32'(bus.wr_ready), 1);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        step(0, 0, 0);
        rst_n = 1'b1;
      end else begin
        step(($urandom_range(0, 3) != 0),
             ($urandom_range(0, 15) == 0),
             (i[7] ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1)));
      end
    end
    step(0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
